// File: rtl/count_sched_pkg.sv
// Shared encodings for the two-requester counter scheduler.
package count_sched_pkg;

  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational winner, registered last winner.
module rr_arb2
  import count_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic win_vld,
  output logic win_owner
);

  logic rr_last;

  always_comb begin
    win_vld   = req_a | req_b;
    win_owner = OWN_A;
    if (req_a && req_b) begin
      win_owner = ~rr_last;
    end else if (req_b) begin
      win_owner = OWN_B;
    end
  end

  // Last winner starts as B so that A takes the first contested grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= OWN_B;
    end else if (take && win_vld) begin
      rr_last <= win_owner;
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin burst scheduler driving the dual event counter's En/Slt.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req_A,
  input  logic [LEN_W-1:0] Len_A,
  input  logic             Sel_A,
  input  logic             Req_B,
  input  logic [LEN_W-1:0] Len_B,
  input  logic             Sel_B,
  input  logic             Hold,
  output logic             Cnt_En,
  output logic             Cnt_Slt,
  output logic             Gnt_A,
  output logic             Gnt_B,
  output logic             Done_A,
  output logic             Done_B,
  output logic             Busy,
  output logic             Owner
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             slt_nxt, own_nxt;
  logic             en_nxt, busy_nxt;
  logic             gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
  logic             win_vld, win_owner;

  rr_arb2 u_arb (
    .clk      (Clk),
    .rst_n    (Reset),
    .req_a    (Req_A),
    .req_b    (Req_B),
    .take     (state == ST_IDLE),
    .win_vld  (win_vld),
    .win_owner(win_owner)
  );

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    slt_nxt    = Cnt_Slt;
    own_nxt    = Owner;
    gnt_a_nxt  = 1'b0;
    gnt_b_nxt  = 1'b0;
    done_a_nxt = 1'b0;
    done_b_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          own_nxt   = win_owner;
          rem_nxt   = (win_owner == OWN_B) ? Len_B : Len_A;
          slt_nxt   = (win_owner == OWN_B) ? Sel_B : Sel_A;
          gnt_a_nxt = (win_owner == OWN_A);
          gnt_b_nxt = (win_owner == OWN_B);
          // A zero-length burst spends its grant cycle in RUN with no
          // enable, so Gnt and Done land in consecutive cycles.
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Cnt_En) begin
          rem_nxt = rem - LEN_W'(1);
        end
        if ((rem == '0) || (Cnt_En && (rem == LEN_W'(1)))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (state_nxt == ST_DONE) begin
      done_a_nxt = (own_nxt == OWN_A);
      done_b_nxt = (own_nxt == OWN_B);
    end

    // Hold seen this cycle gates next cycle's enable; an enable is only
    // issued while cycles are still owed, so rem never goes below zero.
    en_nxt   = (state_nxt == ST_RUN) && !Hold && (rem_nxt != '0);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      rem     <= '0;
      Cnt_En  <= 1'b0;
      Cnt_Slt <= 1'b0;
      Gnt_A   <= 1'b0;
      Gnt_B   <= 1'b0;
      Done_A  <= 1'b0;
      Done_B  <= 1'b0;
      Busy    <= 1'b0;
      Owner   <= OWN_A;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      Cnt_En  <= en_nxt;
      Cnt_Slt <= slt_nxt;
      Gnt_A   <= gnt_a_nxt;
      Gnt_B   <= gnt_b_nxt;
      Done_A  <= done_a_nxt;
      Done_B  <= done_b_nxt;
      Busy    <= busy_nxt;
      Owner   <= own_nxt;
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Randomized scoreboard bench for count_sched against a burst-timeline model.
module tb_count_sched;

  localparam int LEN_W = 8;
  localparam int NC    = 8192;
  localparam int STIM_END = 2000;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Req_A = 1'b0, Sel_A = 1'b0, Req_B = 1'b0, Sel_B = 1'b0, Hold = 1'b0;
  logic [LEN_W-1:0] Len_A = '0, Len_B = '0;
  logic             Cnt_En, Cnt_Slt, Gnt_A, Gnt_B, Done_A, Done_B, Busy, Owner;

  count_sched #(.LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req_A(Req_A), .Len_A(Len_A), .Sel_A(Sel_A),
    .Req_B(Req_B), .Len_B(Len_B), .Sel_B(Sel_B),
    .Hold(Hold),
    .Cnt_En(Cnt_En), .Cnt_Slt(Cnt_Slt),
    .Gnt_A(Gnt_A), .Gnt_B(Gnt_B), .Done_A(Done_A), .Done_B(Done_B),
    .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int owner;
    int sel;
    int len;
    int gnt;
    int done;
  } txn_t;

  txn_t exp_q[$];
  int   en_q[$];
  bit   hold_tab[NC];
  bit   busy_tab[NC];
  bit   mon_on = 1'b0;

  txn_t cur;
  bit   have_cur = 1'b0;
  int   burst_en = 0;

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge Clk) begin
    if (mon_on) begin
      int want_en;
      if (cyc < NC) check("busy", Busy, busy_tab[cyc]);
      if (Gnt_A | Gnt_B | Done_A | Done_B)
        check("pulse_exclusive", $countones({Gnt_A, Gnt_B, Done_A, Done_B}), 1);
      if (Gnt_A | Gnt_B) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", exp_q.size(), 1);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          burst_en = 0;
          check("gnt_cycle", cyc, cur.gnt);
          check("gnt_owner", Gnt_B, cur.owner);
          check("owner_out", Owner, cur.owner);
        end
      end
      if (Cnt_En) begin
        burst_en++;
        if (en_q.size() == 0) begin
          check("en_unexpected", en_q.size(), 1);
        end else begin
          want_en = en_q.pop_front();
          check("en_cycle", cyc, want_en);
        end
        if (have_cur) check("cnt_slt", Cnt_Slt, cur.sel);
      end
      if (Done_A | Done_B) begin
        if (!have_cur) begin
          check("done_unexpected", have_cur, 1);
        end else begin
          check("done_cycle", cyc, cur.done);
          check("done_owner", Done_B, cur.owner);
          check("burst_en_count", burst_en, cur.len);
          have_cur = 1'b0;
        end
      end
    end
  end

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return 255;
    if (r < 4) return 0;
    return $urandom_range(1, 6);
  endfunction

  initial begin
    int  idle_at, rr_last_m, c;
    bit  pend_a, pend_b, drop_a, drop_b;
    int  len_a, len_b, sel_a, sel_b;
    int  count, guard, first;
    bit  seen_done;

    for (int k = 0; k < NC; k++) hold_tab[k] = (k < STIM_END) && ($urandom_range(0, 3) == 0);

    // Reset held for two cycles.
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", {Cnt_En, Cnt_Slt, Gnt_A, Gnt_B, Done_A, Done_B, Busy, Owner}, 8'h00);
    Reset = 1'b1;

    // First requests: A (len 3, ch0) and B (len 255, ch1) together; A must win.
    pend_a = 1; len_a = 3;   sel_a = 0; drop_a = 0;
    pend_b = 1; len_b = 255; sel_b = 1; drop_b = 0;
    idle_at = 0;
    rr_last_m = 1;
    mon_on = 1'b1;

    while (cyc <= idle_at + 3 || cyc < STIM_END) begin
      @(posedge Clk);
      #1;
      c = cyc;
      Hold = hold_tab[c];
      if (c < STIM_END) begin
        if (!pend_a && $urandom_range(0, 3) == 0) begin
          pend_a = 1; len_a = pick_len(); sel_a = $urandom_range(0, 1); drop_a = 1;
        end else if (pend_a && drop_a && $urandom_range(0, 60) == 0) begin
          pend_a = 0;
        end
        if (!pend_b && $urandom_range(0, 3) == 0) begin
          pend_b = 1; len_b = pick_len(); sel_b = $urandom_range(0, 1); drop_b = 1;
        end else if (pend_b && drop_b && $urandom_range(0, 60) == 0) begin
          pend_b = 0;
        end
      end else begin
        pend_a = 0;
        pend_b = 0;
      end
      Req_A = pend_a; Len_A = LEN_W'(len_a); Sel_A = sel_a[0];
      Req_B = pend_b; Len_B = LEN_W'(len_b); Sel_B = sel_b[0];

      // Reference: a request seen while idle wins; the burst occupies the
      // first L cycles after the grant whose preceding cycle had no Hold.
      if (c >= idle_at && (pend_a || pend_b)) begin
        txn_t t;
        int   k, n;
        t.owner = (pend_a && pend_b) ? (1 - rr_last_m) : (pend_b ? 1 : 0);
        rr_last_m = t.owner;
        t.len = (t.owner == 1) ? len_b : len_a;
        t.sel = (t.owner == 1) ? sel_b : sel_a;
        t.gnt = c + 1;
        k = c + 1;
        n = 0;
        while (n < t.len) begin
          if (!hold_tab[k-1]) begin
            en_q.push_back(k);
            n++;
          end
          k++;
        end
        t.done = (t.len == 0) ? c + 2 : k;
        for (int j = c + 1; j <= t.done; j++) busy_tab[j] = 1'b1;
        idle_at = t.done + 1;
        exp_q.push_back(t);
        if (t.owner == 1) pend_b = 0; else pend_a = 0;
      end
    end
    @(negedge Clk);
    mon_on = 1'b0;
    check("exp_q_drained", exp_q.size(), 0);
    check("en_q_drained", en_q.size(), 0);

    // Abort a long A burst with reset on its 10th enable cycle.
    @(posedge Clk);
    #1;
    Hold = 0; Req_A = 1; Len_A = 8'd200; Sel_A = 0; Req_B = 0;
    @(posedge Clk);
    #1;
    Req_A = 0;
    count = 0;
    guard = 0;
    while (count < 10 && guard < 50) begin
      @(negedge Clk);
      if (Cnt_En) count++;
      guard++;
    end
    check("abort_en_seen", count, 10);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_outputs", {Cnt_En, Cnt_Slt, Gnt_A, Gnt_B, Done_A, Done_B, Busy, Owner}, 8'h00);
    seen_done = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Done_A | Done_B) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    // Both request after the abort: round-robin pointer is back to favouring A.
    @(posedge Clk);
    #1;
    Req_A = 1; Len_A = 8'd1; Req_B = 1; Len_B = 8'd1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Gnt_A) begin first = 0; break; end
      if (Gnt_B) begin first = 1; break; end
    end
    check("rr_after_reset", first, 0);
    Req_A = 0; Req_B = 0;
    repeat (4) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
